// File: rtl/traffic_light_monitor.sv
// Passive checker for the two-road traffic-light bus: encoding, phase order, dwell and conflicts.
// Optional dwell watchdog (error code 6) is compiled in with `define TLMON_TIMEOUT_EN.
module traffic_light_monitor #(
  parameter int GREEN_MIN  = 4,
  parameter int YELLOW_CYC = 2,
  parameter int CNT_W      = 16,
  parameter int MAX_DWELL  = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] traffic_A,
  input  logic [2:0] traffic_B,
  output logic       err_valid,
  output logic [2:0] err_code,
  output logic       err_road,
  output logic       err_sticky,
  output logic [7:0] err_count
);

  typedef enum logic [2:0] {
    RED    = 3'b100,
    YELLOW = 3'b010,
    GREEN  = 3'b001
  } light_e;

  typedef enum logic [2:0] {
    ERR_NONE        = 3'd0,
    ERR_ENCODING    = 3'd1,
    ERR_ORDER       = 3'd2,
    ERR_CONFLICT    = 3'd3,
    ERR_SHORT_GREEN = 3'd4,
    ERR_YELLOW      = 3'd5,
    ERR_TIMEOUT     = 3'd6
  } err_code_e;

  typedef struct packed {
    light_e           prev;
    logic [CNT_W-1:0] cnt;
    logic             synced;
  } road_t;

  localparam logic [CNT_W-1:0] GREEN_MIN_C  = CNT_W'(GREEN_MIN);
  localparam logic [CNT_W-1:0] YELLOW_CYC_C = CNT_W'(YELLOW_CYC);
  localparam logic [CNT_W-1:0] CNT_SAT      = '1;
`ifdef TLMON_TIMEOUT_EN
  // The watchdog fires on the increment that lands on MAX_DWELL, i.e. when the old count is one short.
  localparam logic [CNT_W-1:0] DWELL_PRE    = CNT_W'(MAX_DWELL - 1);
`endif

  if ((64'(MAX_DWELL) >= (64'd1 << CNT_W)) || (64'(GREEN_MIN) >= (64'd1 << CNT_W)) ||
      (64'(YELLOW_CYC) >= (64'd1 << CNT_W))) begin : g_param_check
    $error("traffic_light_monitor: dwell parameters do not fit in CNT_W bits");
  end

  function automatic light_e successor(input light_e l);
    case (l)
      GREEN:   return YELLOW;
      YELLOW:  return RED;
      default: return GREEN;
    endcase
  endfunction

  logic [2:0] sample [2];
  road_t      road_q [2];
  road_t      road_d [2];
  logic [1:0] enc_err, order_err, green_err, yellow_err, timeout_err;
  logic       conflict;
  logic       hit;
  err_code_e  code;
  logic       road;

  assign sample[0] = traffic_A;
  assign sample[1] = traffic_B;

  always_comb begin : track
    // NOTE: every signal driven here gets a default first, so no path can leave a latch behind.
    enc_err     = '0;
    order_err   = '0;
    green_err   = '0;
    yellow_err  = '0;
    timeout_err = '0;
    for (int r = 0; r < 2; r++) begin
      road_d[r] = road_q[r];
      if (!$onehot(sample[r])) begin
        enc_err[r]       = 1'b1;
        road_d[r].synced = 1'b0;
      end else if (sample[r] == road_q[r].prev) begin
        if (road_q[r].cnt != CNT_SAT) road_d[r].cnt = road_q[r].cnt + 1'b1;
`ifdef TLMON_TIMEOUT_EN
        timeout_err[r] = road_q[r].synced && (road_q[r].cnt == DWELL_PRE);
`endif
      end else begin
        // An unsynced road only learns its phase here; order and dwell are not yet trustworthy.
        if (road_q[r].synced) begin
          order_err[r]  = sample[r] != successor(road_q[r].prev);
          green_err[r]  = (road_q[r].prev == GREEN) && (road_q[r].cnt < GREEN_MIN_C);
          yellow_err[r] = (road_q[r].prev == YELLOW) && (road_q[r].cnt != YELLOW_CYC_C);
        end
        road_d[r].prev   = light_e'(sample[r]);
        road_d[r].cnt    = CNT_W'(1);
        road_d[r].synced = 1'b1;
      end
    end
  end

  assign conflict = $onehot(sample[0]) && $onehot(sample[1]) &&
                    (sample[0] != RED) && (sample[1] != RED);

  always_comb begin : prioritise
    hit  = 1'b1;
    code = ERR_NONE;
    road = 1'b0;
    if (enc_err[0])          code = ERR_ENCODING;
    else if (enc_err[1])     begin code = ERR_ENCODING;    road = 1'b1; end
    else if (conflict)       code = ERR_CONFLICT;
    else if (order_err[0])   code = ERR_ORDER;
    else if (order_err[1])   begin code = ERR_ORDER;       road = 1'b1; end
    else if (green_err[0])   code = ERR_SHORT_GREEN;
    else if (green_err[1])   begin code = ERR_SHORT_GREEN; road = 1'b1; end
    else if (yellow_err[0])  code = ERR_YELLOW;
    else if (yellow_err[1])  begin code = ERR_YELLOW;      road = 1'b1; end
    else if (timeout_err[0]) code = ERR_TIMEOUT;
    else if (timeout_err[1]) begin code = ERR_TIMEOUT;     road = 1'b1; end
    else                     hit = 1'b0;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < 2; r++) road_q[r] <= '{prev: RED, cnt: '0, synced: 1'b0};
      err_valid  <= 1'b0;
      err_code   <= ERR_NONE;
      err_road   <= 1'b0;
      err_sticky <= 1'b0;
      err_count  <= 8'd0;
    end else begin
      for (int r = 0; r < 2; r++) road_q[r] <= road_d[r];
      err_valid <= hit;
      err_code  <= code;
      err_road  <= road;
      if (hit) err_sticky <= 1'b1;
      if (hit && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Self-checking bench for traffic_light_monitor: directed scenarios plus randomized traffic
// compared against a phase-index reference model. Honours TLMON_TIMEOUT_EN when defined.
module tb_traffic_light_monitor;

  localparam int GREEN_MIN  = 4;
  localparam int YELLOW_CYC = 2;
  localparam int CNT_W      = 16;
  localparam int MAX_DWELL  = 20;
  localparam int CNT_MAX    = (1 << CNT_W) - 1;
  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] traffic_A = R;
  logic [2:0] traffic_B = R;
  logic       err_valid;
  logic [2:0] err_code;
  logic       err_road;
  logic       err_sticky;
  logic [7:0] err_count;

  traffic_light_monitor #(
    .GREEN_MIN (GREEN_MIN),
    .YELLOW_CYC(YELLOW_CYC),
    .CNT_W     (CNT_W),
    .MAX_DWELL (MAX_DWELL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .traffic_A (traffic_A),
    .traffic_B (traffic_B),
    .err_valid (err_valid),
    .err_code  (err_code),
    .err_road  (err_road),
    .err_sticky(err_sticky),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state: last legal light, run length, synced flag per road.
  logic [2:0] m_prev [2];
  int         m_cnt  [2];
  bit         m_sync [2];
  bit         m_sticky;
  int         m_count;
  bit         exp_valid;
  logic [2:0] exp_code;
  logic       exp_road;

  int seen_codes[$];
  int seen_roads[$];
  int step_idx;
  int pulse_step;

  function automatic int phase(input logic [2:0] l);
    if (l == G) return 0;
    if (l == Y) return 1;
    return 2;
  endfunction

  function automatic logic [2:0] advance(input logic [2:0] l);
    if (l == G) return Y;
    if (l == Y) return R;
    return G;
  endfunction

  function automatic string dut_str();
    return $sformatf("valid=%0b code=%0d road=%0b sticky=%0b count=%0d",
                     err_valid, err_code, err_road, err_sticky, err_count);
  endfunction

  function automatic string exp_str();
    return $sformatf("valid=%0b code=%0d road=%0b sticky=%0b count=%0d",
                     exp_valid, exp_code, exp_road, m_sticky, m_count);
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 2; r++) begin
      m_prev[r] = R;
      m_cnt[r]  = 0;
      m_sync[r] = 1'b0;
    end
    m_sticky  = 1'b0;
    m_count   = 0;
    exp_valid = 1'b0;
    exp_code  = 3'd0;
    exp_road  = 1'b0;
  endtask

  task automatic model_step(input logic [2:0] a, input logic [2:0] b);
    logic [2:0] s [2];
    bit         legal [2];
    bit         has [2][7];
    bit         conflict;
    int         prio [6] = '{1, 3, 2, 4, 5, 6};
    s[0] = a;
    s[1] = b;
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 7; c++) has[r][c] = 1'b0;
      legal[r] = ($countones(s[r]) == 1);
      if (!legal[r]) begin
        has[r][1] = 1'b1;
        m_sync[r] = 1'b0;
      end else if (s[r] == m_prev[r]) begin
        bit grew;
        grew = (m_cnt[r] < CNT_MAX);
        if (grew) m_cnt[r]++;
`ifdef TLMON_TIMEOUT_EN
        if (m_sync[r] && grew && m_cnt[r] == MAX_DWELL) has[r][6] = 1'b1;
`endif
      end else begin
        if (m_sync[r]) begin
          if (phase(s[r]) != (phase(m_prev[r]) + 1) % 3) has[r][2] = 1'b1;
          if (m_prev[r] == G && m_cnt[r] < GREEN_MIN) has[r][4] = 1'b1;
          if (m_prev[r] == Y && m_cnt[r] != YELLOW_CYC) has[r][5] = 1'b1;
        end
        m_prev[r] = s[r];
        m_cnt[r]  = 1;
        m_sync[r] = 1'b1;
      end
    end
    conflict  = legal[0] && legal[1] && (s[0] != R) && (s[1] != R);
    exp_valid = 1'b0;
    exp_code  = 3'd0;
    exp_road  = 1'b0;
    for (int p = 0; p < 6 && !exp_valid; p++) begin
      if (prio[p] == 3) begin
        if (conflict) begin
          exp_valid = 1'b1;
          exp_code  = 3'd3;
        end
      end else begin
        for (int r = 0; r < 2 && !exp_valid; r++) begin
          if (has[r][prio[p]]) begin
            exp_valid = 1'b1;
            exp_code  = 3'(prio[p]);
            exp_road  = 1'(r);
          end
        end
      end
    end
    if (exp_valid) begin
      m_sticky = 1'b1;
      if (m_count < 255) m_count++;
    end
  endtask

  // Drive one sample at the falling edge, let the DUT take it, observe at the next falling edge.
  task automatic step(input logic [2:0] a, input logic [2:0] b);
    traffic_A = a;
    traffic_B = b;
    model_step(a, b);
    @(posedge clk);
    @(negedge clk);
    if (err_valid === 1'b1) begin
      seen_codes.push_back(int'(err_code));
      seen_roads.push_back(int'(err_road));
      pulse_step = step_idx;
    end
    step_idx++;
  endtask

  task automatic apply_reset(input logic [2:0] a, input logic [2:0] b);
    rst       = 1'b1;
    traffic_A = a;
    traffic_B = b;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    seen_codes.delete();
    seen_roads.delete();
    step_idx   = 0;
    pulse_step = -1;
  endtask

  task automatic test_reset();
    apply_reset(3'($urandom), 3'($urandom));
    checks++;
    if (err_valid !== 1'b0 || err_code !== 3'd0 || err_road !== 1'b0) begin
      errors++;
      $display("FAIL reset_event: got %s want all zero", dut_str());
    end
    checks++;
    if (err_sticky !== 1'b0 || err_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_status: got sticky=%0b count=%0d want 0 0", err_sticky, err_count);
    end
  endtask

  task automatic test_legal_cycle();
    logic [2:0] qa[$], qb[$];
    apply_reset(R, R);
    for (int rnd = 0; rnd < 3; rnd++) begin
      for (int i = 0; i < 12; i++) begin
        qa.push_back(i < 4 ? G : (i < 6 ? Y : R));
        qb.push_back(R);
      end
      for (int i = 0; i < 7; i++) begin
        qa.push_back(R);
        qb.push_back(i < 4 ? G : (i < 6 ? Y : R));
      end
    end
    for (int i = 0; i < qa.size(); i++) begin
      step(qa[i], qb[i]);
      checks++;
      if (err_valid !== exp_valid || err_sticky !== m_sticky || err_count !== 8'(m_count) ||
          (exp_valid && (err_code !== exp_code || err_road !== exp_road))) begin
        errors++;
        $display("FAIL legal_cycle step %0d: got %s want %s", i, dut_str(), exp_str());
      end
    end
    checks++;
    if (seen_codes.size() != 0 || err_count !== 8'd0 || err_sticky !== 1'b0) begin
      errors++;
      $display("FAIL legal_cycle_clean: got %0d reports count=%0d sticky=%0b want 0 0 0",
               seen_codes.size(), err_count, err_sticky);
    end
  endtask

  task automatic test_conflict();
    apply_reset(R, R);
    step(R, R);
    step(G, G);
    checks++;
    if (err_valid !== 1'b1 || err_code !== 3'd3 || err_road !== 1'b0 ||
        err_sticky !== 1'b1 || err_count !== 8'd1) begin
      errors++;
      $display("FAIL conflict: got %s want valid=1 code=3 road=0 sticky=1 count=1", dut_str());
    end
  endtask

  task automatic test_dwell();
    logic [2:0] qb[$] = '{R, G, G, G, G, Y, Y, R, G, G, G, Y, Y, Y, R};
    apply_reset(R, R);
    for (int i = 0; i < qb.size(); i++) begin
      step(R, qb[i]);
      checks++;
      if (err_valid !== exp_valid || err_sticky !== m_sticky || err_count !== 8'(m_count) ||
          (exp_valid && (err_code !== exp_code || err_road !== exp_road))) begin
        errors++;
        $display("FAIL dwell step %0d: got %s want %s", i, dut_str(), exp_str());
      end
    end
    checks++;
    if (seen_codes.size() != 2 || seen_codes[0] != 4 || seen_roads[0] != 1 ||
        seen_codes[1] != 5 || seen_roads[1] != 1 || err_count !== 8'd2) begin
      errors++;
      $display("FAIL dwell_reports: got %0d reports count=%0d want codes 4,5 on road 1 count=2",
               seen_codes.size(), err_count);
    end
  endtask

  task automatic test_order_encoding();
    logic [2:0] qa[$] = '{R, G, G, G, G, R, 3'b110, R, R, G};
    apply_reset(R, R);
    for (int i = 0; i < qa.size(); i++) begin
      step(qa[i], R);
      checks++;
      if (err_valid !== exp_valid || err_sticky !== m_sticky || err_count !== 8'(m_count) ||
          (exp_valid && (err_code !== exp_code || err_road !== exp_road))) begin
        errors++;
        $display("FAIL order_encoding step %0d: got %s want %s", i, dut_str(), exp_str());
      end
    end
    checks++;
    if (seen_codes.size() != 2 || seen_codes[0] != 2 || seen_roads[0] != 0 ||
        seen_codes[1] != 1 || seen_roads[1] != 0 || err_count !== 8'd2) begin
      errors++;
      $display("FAIL order_encoding_reports: got %0d reports count=%0d want codes 2,1 on road 0 count=2",
               seen_codes.size(), err_count);
    end
  endtask

  task automatic test_reset_priority();
    apply_reset(R, R);
    step(G, G);
    apply_reset(G, R);
    checks++;
    if (err_valid !== 1'b0 || err_sticky !== 1'b0 || err_count !== 8'd0) begin
      errors++;
      $display("FAIL mid_reset: got %s want valid=0 sticky=0 count=0", dut_str());
    end
    step(3'b011, G);
    checks++;
    if (err_valid !== 1'b1 || err_code !== 3'd1 || err_road !== 1'b0 || err_count !== 8'd1) begin
      errors++;
      $display("FAIL priority: got %s want valid=1 code=1 road=0 count=1", dut_str());
    end
  endtask

  task automatic test_timeout();
    int exp_n;
`ifdef TLMON_TIMEOUT_EN
    exp_n = 1;
`else
    exp_n = 0;
`endif
    apply_reset(R, R);
    for (int i = 0; i < 36; i++) begin
      step(i < 4 ? G : (i < 6 ? Y : R), R);
      checks++;
      if (err_valid !== exp_valid || err_sticky !== m_sticky || err_count !== 8'(m_count) ||
          (exp_valid && (err_code !== exp_code || err_road !== exp_road))) begin
        errors++;
        $display("FAIL timeout step %0d: got %s want %s", i, dut_str(), exp_str());
      end
    end
    // Red starts at step 6 with a run of 1, so the run reaches MAX_DWELL at step 6+MAX_DWELL-1.
    checks++;
    if (seen_codes.size() != exp_n ||
        (exp_n == 1 && (seen_codes[0] != 6 || seen_roads[0] != 0 || pulse_step != 5 + MAX_DWELL))) begin
      errors++;
      $display("FAIL timeout_pulse: got %0d reports last at step %0d want %0d at step %0d",
               seen_codes.size(), pulse_step, exp_n, 5 + MAX_DWELL);
    end
  endtask

  task automatic test_count_saturation();
    apply_reset(R, R);
    for (int i = 0; i < 260; i++) begin
      step(3'b000, R);
      checks++;
      if (err_valid !== exp_valid || err_sticky !== m_sticky || err_count !== 8'(m_count) ||
          (exp_valid && (err_code !== exp_code || err_road !== exp_road))) begin
        errors++;
        $display("FAIL saturation step %0d: got %s want %s", i, dut_str(), exp_str());
      end
    end
    checks++;
    if (err_count !== 8'd255 || err_sticky !== 1'b1) begin
      errors++;
      $display("FAIL saturation_final: got count=%0d sticky=%0b want 255 1", err_count, err_sticky);
    end
  endtask

  task automatic test_random();
    logic [2:0] cur [2];
    apply_reset(R, R);
    cur[0] = R;
    cur[1] = R;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(99) == 0) apply_reset(3'($urandom), 3'($urandom));
      for (int r = 0; r < 2; r++) begin
        int pick;
        pick = $urandom_range(99);
        if (pick >= 55 && pick < 85)      cur[r] = advance(cur[r]);
        else if (pick >= 85 && pick < 93) cur[r] = 3'b001 << $urandom_range(2);
        else if (pick >= 93)              cur[r] = 3'($urandom);
      end
      step(cur[0], cur[1]);
      checks++;
      if (err_valid !== exp_valid || err_sticky !== m_sticky || err_count !== 8'(m_count) ||
          (exp_valid && (err_code !== exp_code || err_road !== exp_road))) begin
        errors++;
        $display("FAIL random step %0d: A=%b B=%b got %s want %s",
                 i, cur[0], cur[1], dut_str(), exp_str());
      end
    end
  endtask

  initial begin
    model_reset();
    step_idx   = 0;
    pulse_step = -1;
    @(negedge clk);
    test_reset();
    test_legal_cycle();
    test_conflict();
    test_dwell();
    test_order_encoding();
    test_reset_priority();
    test_timeout();
    test_count_saturation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
